// File: rtl/hall_commutation_ctrl.sv
// Six-step BLDC commutation from hall sensors with dead-time, braking and fault latch.
// Optional stall detection is built when HALL_STALL_DETECT_EN is defined.
//
// state   | meaning
// IDLE    | drive disabled, all gates off
// DEAD    | all gates off for DEADTIME cycles before a new pattern
// RUN     | commutation pattern for the current sector and direction
// BRAKE   | all low sides on, high sides off
// FAULT   | latched fault, all gates off until en drops
module hall_commutation_ctrl #(
  parameter int DEADTIME     = 8,
  parameter int STALL_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       brake,
  input  logic       pwm,
  input  logic       SA_in,
  input  logic       SB_in,
  input  logic       SC_in,
  output logic       AH,
  output logic       AL,
  output logic       BH,
  output logic       BL,
  output logic       CH,
  output logic       CL,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       step_pulse,
  output logic       dir_meas
);

  if (DEADTIME < 1 || DEADTIME > 255 || STALL_CYCLES < 2 || STALL_CYCLES > 1048575) begin : g_param_check
    $error("hall_commutation_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_DEAD, S_RUN, S_BRAKE, S_FAULT} state_t;

  localparam logic [7:0] DEAD_LOAD = 8'(DEADTIME - 1);

  function automatic logic [2:0] sector_of(input logic [2:0] h);
    case (h)
      3'b101:  sector_of = 3'd1;
      3'b100:  sector_of = 3'd2;
      3'b110:  sector_of = 3'd3;
      3'b010:  sector_of = 3'd4;
      3'b011:  sector_of = 3'd5;
      3'b001:  sector_of = 3'd6;
      default: sector_of = 3'd0;
    endcase
  endfunction

  // bit order {AH, AL, BH, BL, CH, CL}; reverse swaps H/L within each phase
  function automatic logic [5:0] pattern_of(input logic [2:0] s, input logic fwd);
    logic [5:0] p;
    case (s)
      3'd1:    p = 6'b100100;
      3'd2:    p = 6'b100001;
      3'd3:    p = 6'b001001;
      3'd4:    p = 6'b011000;
      3'd5:    p = 6'b010010;
      3'd6:    p = 6'b000110;
      default: p = 6'b000000;
    endcase
    pattern_of = fwd ? p : {p[4], p[5], p[2], p[3], p[0], p[1]};
  endfunction

  state_t     state_q, state_d;
  logic [2:0] hall_q, hall_p;
  logic [7:0] dead_cnt_q, dead_cnt_d;
  logic [5:0] gate_q, gate_d;
  logic       fault_d, step_d, dmeas_d, run_dir_q, run_dir_d;
  logic [1:0] code_d;

  logic [2:0] sec_new, sec_old;
  logic       illegal, chg, fwd_step, rev_step, acc, seq_err, stall_hit;

  assign sec_new  = sector_of(hall_q);
  assign sec_old  = sector_of(hall_p);
  assign illegal  = (sec_new == 3'd0);
  assign chg      = (hall_q != hall_p);
  assign fwd_step = (sec_new == ((sec_old == 3'd6) ? 3'd1 : sec_old + 3'd1));
  assign rev_step = (sec_new == ((sec_old == 3'd1) ? 3'd6 : sec_old - 3'd1));
  assign acc      = chg && !illegal && (fwd_step || rev_step);
  assign seq_err  = chg && !illegal && !acc;

`ifdef HALL_STALL_DETECT_EN
  logic [19:0] stall_cnt_q;
  logic        active;

  assign active    = (state_q == S_DEAD) || (state_q == S_RUN);
  assign stall_hit = active && (stall_cnt_q == 20'(STALL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !active || acc) stall_cnt_q <= '0;
    else                       stall_cnt_q <= stall_cnt_q + 20'd1;
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    fault_d    = fault;
    code_d     = fault_code;
    step_d     = 1'b0;
    dmeas_d    = dir_meas;
    run_dir_d  = run_dir_q;
    if (!en) begin
      state_d = S_IDLE;
      fault_d = 1'b0;
      code_d  = 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!illegal) begin
            state_d    = S_DEAD;
            dead_cnt_d = DEAD_LOAD;
          end
        end
        S_FAULT: ;
        default: begin
          if (illegal) begin
            state_d = S_FAULT; fault_d = 1'b1; code_d = 2'b01;
          end else if (seq_err) begin
            state_d = S_FAULT; fault_d = 1'b1; code_d = 2'b10;
          end else if (stall_hit) begin
            state_d = S_FAULT; fault_d = 1'b1; code_d = 2'b11;
          end else begin
            if (acc) begin
              step_d  = 1'b1;
              dmeas_d = fwd_step;
            end
            case (state_q)
              S_DEAD: begin
                if (acc)                    dead_cnt_d = DEAD_LOAD;
                else if (dead_cnt_q == '0)  state_d = brake ? S_BRAKE : S_RUN;
                else                        dead_cnt_d = dead_cnt_q - 8'd1;
              end
              S_RUN: begin
                if (brake || acc || (dir != run_dir_q)) begin
                  state_d    = S_DEAD;
                  dead_cnt_d = DEAD_LOAD;
                end
              end
              S_BRAKE: begin
                if (!brake) begin
                  state_d    = S_DEAD;
                  dead_cnt_d = DEAD_LOAD;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
    case (state_d)
      S_RUN:   gate_d = pattern_of(sec_new, dir);
      S_BRAKE: gate_d = 6'b010101;
      default: gate_d = 6'b000000;
    endcase
    if (state_d == S_RUN) run_dir_d = dir;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hall_q     <= '0;
      hall_p     <= '0;
      dead_cnt_q <= '0;
      gate_q     <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      step_pulse <= 1'b0;
      dir_meas   <= 1'b0;
      run_dir_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hall_q     <= {SA_in, SB_in, SC_in};
      hall_p     <= hall_q;
      dead_cnt_q <= dead_cnt_d;
      gate_q     <= gate_d;
      fault      <= fault_d;
      fault_code <= code_d;
      step_pulse <= step_d;
      dir_meas   <= dmeas_d;
      run_dir_q  <= run_dir_d;
    end
  end

  // high sides are chopped by pwm after the register, low sides are not
  assign AH = gate_q[5] & pwm;
  assign AL = gate_q[4];
  assign BH = gate_q[3] & pwm;
  assign BL = gate_q[2];
  assign CH = gate_q[1] & pwm;
  assign CL = gate_q[0];

endmodule

// File: tb/tb_hall_commutation_ctrl.sv
// Bench for hall_commutation_ctrl: directed scenarios followed by a random hall walk,
// every cycle compared against a behavioural model of the commutation rules.
module tb_hall_commutation_ctrl;
  localparam int DT    = 8;
  localparam int STALL = 100;
`ifdef HALL_STALL_DETECT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_DEAD = 1, M_RUN = 2, M_BRAKE = 3, M_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst, en, dir, brake, pwm;
  logic [2:0] hall;
  logic       AH, AL, BH, BL, CH, CL, fault, step_pulse, dir_meas;
  logic [1:0] fault_code;

  hall_commutation_ctrl #(.DEADTIME(DT), .STALL_CYCLES(STALL)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .brake(brake), .pwm(pwm),
    .SA_in(hall[2]), .SB_in(hall[1]), .SC_in(hall[0]),
    .AH(AH), .AL(AL), .BH(BH), .BL(BL), .CH(CH), .CL(CL),
    .fault(fault), .fault_code(fault_code), .step_pulse(step_pulse), .dir_meas(dir_meas)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // hall code -> sector, sector -> hall code
  int sec_lut  [8] = '{0, 6, 4, 5, 2, 1, 3, 0};
  int code_lut [7] = '{0, 5, 4, 6, 2, 3, 1};

  int         cyc = 0;
  int         m_mode = M_IDLE, m_dead_end = 0, m_stall_base = 0, m_run_sec = 1;
  logic [2:0] m_hq = 3'b000, m_hp = 3'b000;
  bit         m_run_dir = 1'b0, m_fault = 1'b0, m_step = 1'b0, m_dmeas = 1'b0;
  logic [1:0] m_code = 2'b00;

  function automatic logic [5:0] exp_gates();
    logic [5:0] g;
    int hi, lo, t;
    g = '0;
    if (m_mode == M_BRAKE) g = 6'b010101;
    else if (m_mode == M_RUN) begin
      hi = (m_run_sec - 1) / 2;
      lo = (m_run_sec / 2 + 1) % 3;
      if (!m_run_dir) begin t = hi; hi = lo; lo = t; end
      g[5 - 2*hi] = pwm;
      g[4 - 2*lo] = 1'b1;
    end
    return g;
  endfunction

  task automatic set_fault(input logic [1:0] c, inout int nm);
    nm = M_FAULT; m_fault = 1'b1; m_code = c;
  endtask

  // advances the model by one rising edge using the inputs currently driven
  task automatic model_edge();
    int sn, so, d, nm;
    bit ill, chg, fwd, acc, seqe, stl, active;
    if (rst) begin
      m_mode = M_IDLE; m_fault = 0; m_code = 0; m_step = 0; m_dmeas = 0;
      m_hq = 0; m_hp = 0; m_stall_base = cyc + 1;
    end else begin
      sn     = sec_lut[m_hq];
      so     = sec_lut[m_hp];
      ill    = (sn == 0);
      chg    = (m_hq != m_hp);
      d      = (sn - so + 6) % 6;
      fwd    = chg && !ill && d == 1;
      acc    = chg && !ill && (d == 1 || d == 5);
      seqe   = chg && !ill && !acc;
      active = (m_mode == M_DEAD) || (m_mode == M_RUN);
      stl    = STALL_EN && active && (cyc - m_stall_base == STALL - 1);
      if (!active || acc) m_stall_base = cyc + 1;
      nm     = m_mode;
      m_step = 1'b0;
      if (!en) begin
        nm = M_IDLE; m_fault = 0; m_code = 0;
      end else if (m_mode == M_IDLE) begin
        if (!ill) begin nm = M_DEAD; m_dead_end = cyc + DT; end
      end else if (m_mode != M_FAULT) begin
        if (ill)       set_fault(2'b01, nm);
        else if (seqe) set_fault(2'b10, nm);
        else if (stl)  set_fault(2'b11, nm);
        else begin
          if (acc) begin m_step = 1'b1; m_dmeas = fwd; end
          if (m_mode == M_DEAD) begin
            if (acc) m_dead_end = cyc + DT;
            else if (cyc == m_dead_end) nm = brake ? M_BRAKE : M_RUN;
          end else if (m_mode == M_RUN) begin
            if (brake || acc || (dir != m_run_dir)) begin nm = M_DEAD; m_dead_end = cyc + DT; end
          end else if (!brake) begin
            nm = M_DEAD; m_dead_end = cyc + DT;
          end
        end
      end
      if (nm == M_RUN) begin m_run_sec = sn; m_run_dir = dir; end
      m_mode = nm;
      m_hp   = m_hq;
      m_hq   = hall;
    end
    cyc++;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_eq("gates", {26'd0, AH, AL, BH, BL, CH, CL}, {26'd0, exp_gates()});
    check_eq("status", {27'd0, fault, fault_code, step_pulse, dir_meas},
             {27'd0, m_fault, m_code, m_step, m_dmeas});
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [5:0] gates_now();
    return {AH, AL, BH, BL, CH, CL};
  endfunction

  initial begin
    int offc, steps, ps, r;
    rst = 1; en = 0; dir = 1; brake = 0; pwm = 1; hall = 3'b101;
    run_n(2);
    check_eq("reset_gates", {26'd0, gates_now()}, 0);
    check_eq("reset_status", {27'd0, fault, fault_code, step_pulse, dir_meas}, 0);

    // enable in sector 1: one idle sample, eight dead cycles, then AH+BL
    rst = 0; en = 1; offc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (gates_now() == 6'b0) offc++;
    end
    check_eq("req035_off_cycles", offc, 9);
    check_eq("req035_run", {26'd0, gates_now()}, 32'b100100);

    // forward step 1 -> 2
    hall = 3'b100; offc = 0; steps = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (gates_now() == 6'b0) offc++;
      if (step_pulse) steps++;
    end
    check_eq("req036_steps", steps, 1);
    check_eq("req036_off_cycles", offc, 8);
    check_eq("req036_dir_meas", {31'd0, dir_meas}, 1);
    check_eq("req036_run", {26'd0, gates_now()}, 32'b100001);
    pwm = 0;
    cycle();
    check_eq("req036_pwm_low", {26'd0, gates_now()}, 32'b000001);
    pwm = 1;

    // non-adjacent jump 2 -> 4
    hall = 3'b010;
    run_n(3);
    check_eq("req037_fault", {29'd0, fault, fault_code}, 32'b110);
    check_eq("req037_gates", {26'd0, gates_now()}, 0);
    en = 0;
    cycle();
    check_eq("req037_clear", {29'd0, fault, fault_code}, 0);
    en = 1;
    run_n(10);
    check_eq("req037_recover", {26'd0, gates_now()}, 32'b011000);

    // reverse step 4 -> 3, then brake and release
    hall = 3'b110;
    run_n(12);
    check_eq("req038_dir_meas", {31'd0, dir_meas}, 0);
    check_eq("req038_run", {26'd0, gates_now()}, 32'b001001);
    brake = 1;
    run_n(10);
    check_eq("req038_brake", {26'd0, gates_now()}, 32'b010101);
    brake = 0;
    run_n(10);
    check_eq("req038_unbrake", {26'd0, gates_now()}, 32'b001001);
    hall = 3'b111;
    run_n(3);
    check_eq("req038_illegal", {29'd0, fault, fault_code}, 32'b101);
    en = 0; cycle(); en = 1;

    // static hall in RUN
    hall = 3'b101;
    run_n(160);
`ifdef HALL_STALL_DETECT_EN
    check_eq("req039_stall", {29'd0, fault, fault_code}, 32'b111);
`else
    check_eq("req039_no_stall", {29'd0, fault, fault_code}, 0);
    check_eq("req039_run", {26'd0, gates_now()}, 32'b100100);
`endif
    en = 0; cycle(); en = 1;

    // reset in the middle of a dead interval
    run_n(10);
    hall = 3'b100;
    run_n(4);
    rst = 1;
    cycle();
    check_eq("req040_gates", {26'd0, gates_now()}, 0);
    check_eq("req040_status", {27'd0, fault, fault_code, step_pulse, dir_meas}, 0);
    rst = 0;

    // random hall walk with occasional faults, brake, direction and enable changes
    ps = 2;
    for (int i = 0; i < 3000; i++) begin
      pwm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 79) == 0) dir = ~dir;
      if ($urandom_range(0, 59) == 0) brake = ~brake;
      if (rst) rst = 0;
      else if ($urandom_range(0, 799) == 0) rst = 1;
      if (!en) en = ($urandom_range(0, 2) == 0);
      else if (m_fault && $urandom_range(0, 9) == 0) en = 0;
      else if ($urandom_range(0, 299) == 0) en = 0;
      if ($urandom_range(0, 13) == 0) begin
        r = int'($urandom_range(0, 99));
        if (r < 45)      ps = ps % 6 + 1;
        else if (r < 90) ps = (ps + 4) % 6 + 1;
        else if (r < 95) ps = (ps + 1) % 6 + 1;
        if (r < 95) hall = 3'(code_lut[ps]);
        else        hall = (r % 2 == 0) ? 3'b000 : 3'b111;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
